// File: rtl/unified_mem_arbiter_if.sv
// Request/response bundle between the fetch and memory stages, the arbiter, and the
// single-port memory macro.
interface unified_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                      if_req;
   logic [ADDR_WIDTH-1:0]     if_addr;
   logic                      if_kill;
   logic                      if_gnt;
   logic                      if_rvalid;
   logic [DATA_WIDTH-1:0]     if_rdata;

   logic                      dm_req;
   logic                      dm_we;
   logic [DATA_WIDTH/8-1:0]   dm_be;
   logic [ADDR_WIDTH-1:0]     dm_addr;
   logic [DATA_WIDTH-1:0]     dm_wdata;
   logic                      dm_gnt;
   logic                      dm_rvalid;
   logic [DATA_WIDTH-1:0]     dm_rdata;

   logic                      mem_en;
   logic                      mem_we;
   logic [DATA_WIDTH/8-1:0]   mem_be;
   logic [ADDR_WIDTH-1:0]     mem_addr;
   logic [DATA_WIDTH-1:0]     mem_wdata;
   logic [DATA_WIDTH-1:0]     mem_rdata;

   logic                      busy;

   // Requesters plus the memory macro drive the arbiter inputs.
   modport master (
      output if_req, if_addr, if_kill,
      output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  dm_gnt, dm_rvalid, dm_rdata,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  busy
   );

   modport slave (
      input  if_req, if_addr, if_kill,
      input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output dm_gnt, dm_rvalid, dm_rdata,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output busy
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between instruction fetch and
// the memory stage; one transaction in flight, response routed to its issuer.
module unified_mem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   unified_mem_arbiter_if.slave bus
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
   localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);
   localparam logic [STV_W-1:0] STV_ZERO = STV_W'(0);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_e;

   state_e             state_r,  state_nxt_s;
   owner_e             owner_r,  owner_nxt_s;
   logic [CNT_W-1:0]   cnt_r,    cnt_nxt_s;
   logic [STV_W-1:0]   starve_r, starve_nxt_s;
   logic               killed_r, killed_nxt_s;
   logic               we_r,     we_nxt_s;

   logic               resp_s;
   logic               window_s;
   logic               if_win_s;
   logic               issue_s;

   // Transaction-tracking registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= S_IDLE;
         owner_r  <= OWN_NONE;
         cnt_r    <= CNT_ZERO;
         starve_r <= STV_ZERO;
         killed_r <= 1'b0;
         we_r     <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         owner_r  <= owner_nxt_s;
         cnt_r    <= cnt_nxt_s;
         starve_r <= starve_nxt_s;
         killed_r <= killed_nxt_s;
         we_r     <= we_nxt_s;
      end
   end

   // Arbitration, issue, response routing and next-state selection.
   always_comb begin
      state_nxt_s   = state_r;
      owner_nxt_s   = owner_r;
      cnt_nxt_s     = cnt_r;
      starve_nxt_s  = starve_r;
      killed_nxt_s  = killed_r;
      we_nxt_s      = we_r;

      bus.if_gnt    = 1'b0;
      bus.if_rvalid = 1'b0;
      bus.if_rdata  = '0;
      bus.dm_gnt    = 1'b0;
      bus.dm_rvalid = 1'b0;
      bus.dm_rdata  = '0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_be    = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.busy      = 1'b0;

      // The response cycle doubles as an issue slot so accesses can go back-to-back.
      resp_s   = (state_r == S_WAIT) && (cnt_r == CNT_ZERO);
      window_s = (state_r == S_IDLE) || resp_s;
      if_win_s = bus.if_req && (!bus.dm_req || (starve_r >= STV_MAX));
      issue_s  = !rst && window_s && (bus.if_req || bus.dm_req);

      if (issue_s) begin
         bus.mem_en = 1'b1;
         if (if_win_s) begin
            bus.if_gnt   = 1'b1;
            bus.mem_addr = bus.if_addr;
            bus.mem_be   = '1;
         end else begin
            bus.dm_gnt    = 1'b1;
            bus.mem_we    = bus.dm_we;
            bus.mem_be    = bus.dm_be;
            bus.mem_addr  = bus.dm_addr;
            bus.mem_wdata = bus.dm_wdata;
         end
      end else begin
         bus.mem_en = 1'b0;
      end

      if (!rst && resp_s) begin
         case (owner_r)
            OWN_IF: begin
               if (!killed_r && !bus.if_kill) begin
                  bus.if_rvalid = 1'b1;
                  bus.if_rdata  = bus.mem_rdata;
               end else begin
                  bus.if_rvalid = 1'b0;
               end
            end
            OWN_DM: begin
               bus.dm_rvalid = 1'b1;
               bus.dm_rdata  = we_r ? '0 : bus.mem_rdata;
            end
            default: begin
               bus.dm_rvalid = 1'b0;
            end
         endcase
      end else begin
         bus.if_rvalid = 1'b0;
      end

      bus.busy = !rst && (state_r == S_WAIT);

      // Starvation only accrues when IF actually lost a real arbitration.
      if (issue_s && !if_win_s && bus.if_req) begin
         starve_nxt_s = (starve_r >= STV_MAX) ? STV_MAX : (starve_r + STV_ONE);
      end else if ((issue_s && if_win_s) || !bus.if_req) begin
         starve_nxt_s = STV_ZERO;
      end else begin
         starve_nxt_s = starve_r;
      end

      case (state_r)
         S_IDLE: begin
            if (issue_s) begin
               state_nxt_s  = S_WAIT;
               cnt_nxt_s    = CNT_LOAD;
               owner_nxt_s  = if_win_s ? OWN_IF : OWN_DM;
               killed_nxt_s = if_win_s && bus.if_kill;
               we_nxt_s     = !if_win_s && bus.dm_we;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (issue_s) begin
               state_nxt_s  = S_WAIT;
               cnt_nxt_s    = CNT_LOAD;
               owner_nxt_s  = if_win_s ? OWN_IF : OWN_DM;
               killed_nxt_s = if_win_s && bus.if_kill;
               we_nxt_s     = !if_win_s && bus.dm_we;
            end else if (resp_s) begin
               state_nxt_s  = S_IDLE;
               owner_nxt_s  = OWN_NONE;
               killed_nxt_s = 1'b0;
               we_nxt_s     = 1'b0;
            end else begin
               cnt_nxt_s    = cnt_r - CNT_ONE;
               killed_nxt_s = killed_r || ((owner_r == OWN_IF) && bus.if_kill);
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
            owner_nxt_s = OWN_NONE;
         end
      endcase
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized and directed bench for unified_mem_arbiter against a cycle-count based
// reference model of the arbitration and response rules.
module tb_unified_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int BW  = DW / 8;
   localparam int LAT = 2;
   localparam int LIM = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   unified_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   unified_mem_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: absolute cycle at which the pending response is due.
   int cyc = 0;
   bit m_busy = 1'b0;
   int m_due = 0;
   bit m_own_if = 1'b0;
   bit m_own_we = 1'b0;
   bit m_killed = 1'b0;
   int m_losses = 0;
   bit last_if_gnt = 1'b0;
   bit last_dm_gnt = 1'b0;

   logic          s_if_gnt, s_if_rvalid, s_dm_gnt, s_dm_rvalid, s_mem_en, s_mem_we, s_busy;
   logic [DW-1:0] s_if_rdata, s_dm_rdata, s_mem_wdata;
   logic [AW-1:0] s_mem_addr;
   logic [BW-1:0] s_mem_be;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s @cycle %0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      bit resp, win, ifw, iss;
      bit e_ig, e_dg, e_en, e_we, e_irv, e_drv, e_busy;
      logic [DW-1:0] e_ird, e_drd, e_wd;
      logic [AW-1:0] e_addr;
      logic [BW-1:0] e_be;
      @(negedge clk);
      s_if_gnt = bus.if_gnt;     s_if_rvalid = bus.if_rvalid; s_if_rdata = bus.if_rdata;
      s_dm_gnt = bus.dm_gnt;     s_dm_rvalid = bus.dm_rvalid; s_dm_rdata = bus.dm_rdata;
      s_mem_en = bus.mem_en;     s_mem_we = bus.mem_we;       s_mem_be = bus.mem_be;
      s_mem_addr = bus.mem_addr; s_mem_wdata = bus.mem_wdata; s_busy = bus.busy;

      resp = m_busy && (cyc == m_due);
      win  = !m_busy || resp;
      ifw  = bus.if_req && (!bus.dm_req || (m_losses >= LIM));
      iss  = win && (bus.if_req || bus.dm_req);
      {e_ig, e_dg, e_en, e_we, e_irv, e_drv, e_busy} = 7'b0;
      e_ird = '0; e_drd = '0; e_wd = '0; e_addr = '0; e_be = '0;
      if (!rst) begin
         if (iss) begin
            e_en = 1'b1;
            if (ifw) begin
               e_ig = 1'b1; e_addr = bus.if_addr; e_be = '1;
            end else begin
               e_dg = 1'b1; e_we = bus.dm_we; e_be = bus.dm_be;
               e_addr = bus.dm_addr; e_wd = bus.dm_wdata;
            end
         end
         if (resp) begin
            if (m_own_if) begin
               e_irv = !m_killed && !bus.if_kill;
               e_ird = e_irv ? bus.mem_rdata : '0;
            end else begin
               e_drv = 1'b1;
               e_drd = m_own_we ? '0 : bus.mem_rdata;
            end
         end
         e_busy = m_busy;
      end

      chk("if_gnt", s_if_gnt, e_ig);       chk("dm_gnt", s_dm_gnt, e_dg);
      chk("if_rvalid", s_if_rvalid, e_irv); chk("if_rdata", s_if_rdata, e_ird);
      chk("dm_rvalid", s_dm_rvalid, e_drv); chk("dm_rdata", s_dm_rdata, e_drd);
      chk("mem_en", s_mem_en, e_en);       chk("mem_we", s_mem_we, e_we);
      chk("mem_be", s_mem_be, e_be);       chk("mem_addr", s_mem_addr, e_addr);
      chk("mem_wdata", s_mem_wdata, e_wd); chk("busy", s_busy, e_busy);
      last_if_gnt = e_ig;
      last_dm_gnt = e_dg;

      @(posedge clk);
      if (rst) begin
         m_busy = 1'b0; m_killed = 1'b0; m_losses = 0;
      end else begin
         if (iss) begin
            m_busy = 1'b1; m_due = cyc + LAT; m_own_if = ifw;
            m_own_we = !ifw && bus.dm_we;
            m_killed = ifw && bus.if_kill;
         end else if (resp) begin
            m_busy = 1'b0;
         end else if (m_busy && m_own_if && bus.if_kill) begin
            m_killed = 1'b1;
         end
         if (iss && !ifw && bus.if_req) m_losses = (m_losses >= LIM) ? LIM : m_losses + 1;
         else if ((iss && ifw) || !bus.if_req) m_losses = 0;
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.if_kill = 1'b0; bus.dm_we = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      bus.if_req = 1'b0; bus.if_addr = '0; bus.if_kill = 1'b0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
      bus.mem_rdata = '0;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      idle(2);

      // Plain IF read.
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
      step();
      chk("p1 if_gnt", s_if_gnt, 1'b1); chk("p1 mem_addr", s_mem_addr, 32'h0000_0100);
      bus.if_req = 1'b0; bus.if_addr = '0;
      step();
      bus.mem_rdata = 32'h0000_0013;
      step();
      chk("p1 if_rvalid", s_if_rvalid, 1'b1); chk("p1 if_rdata", s_if_rdata, 32'h0000_0013);
      chk("p1 dm_rvalid", s_dm_rvalid, 1'b0);
      idle(2);

      // Simultaneous IF and DM: DM first, IF issued in DM response cycle.
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0040;
      bus.mem_rdata = 32'hA5A5_0001;
      step();
      chk("p2 dm_gnt", s_dm_gnt, 1'b1); chk("p2 if_gnt0", s_if_gnt, 1'b0);
      bus.dm_req = 1'b0;
      step(); step();
      chk("p2 dm_rvalid", s_dm_rvalid, 1'b1); chk("p2 if_gnt2", s_if_gnt, 1'b1);
      bus.if_req = 1'b0;
      step(); step();
      chk("p2 if_rvalid", s_if_rvalid, 1'b1);
      idle(2);

      // Starvation: both held high.
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0200;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0080;
      for (int k = 0; k < 12; k++) begin
         step();
         chk("p3 dm_gnt", s_dm_gnt, ((k % 2) == 0) && (k != 8));
         chk("p3 if_gnt", s_if_gnt, k == 8);
      end
      idle(3);

      // DM write with partial byte enables.
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_be = 4'b0011;
      bus.dm_addr = 32'h0000_0044; bus.dm_wdata = 32'hDEAD_BEEF;
      step();
      chk("p4 mem_we", s_mem_we, 1'b1); chk("p4 mem_be", s_mem_be, 4'b0011);
      chk("p4 mem_wdata", s_mem_wdata, 32'hDEAD_BEEF);
      bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      step();
      bus.mem_rdata = 32'h1234_5678;
      step();
      chk("p4 dm_rvalid", s_dm_rvalid, 1'b1); chk("p4 dm_rdata", s_dm_rdata, 32'h0);
      idle(2);

      // Kill of an outstanding fetch, followed by a fresh fetch.
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0300;
      step();
      bus.if_req = 1'b0; bus.if_kill = 1'b1;
      step();
      bus.if_kill = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h0000_0304;
      step();
      chk("p5 if_rvalid_killed", s_if_rvalid, 1'b0); chk("p5 if_gnt", s_if_gnt, 1'b1);
      bus.if_req = 1'b0;
      step(); step();
      chk("p5 if_rvalid", s_if_rvalid, 1'b1);
      idle(2);

      // Reset in the middle of a fetch.
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0400;
      step();
      bus.if_req = 1'b0;
      rst = 1'b1;
      #1;
      chk("p6 busy_async", bus.busy, 1'b0);
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("p6 if_rvalid", s_if_rvalid, 1'b0);
      end
      idle(2);

      // Randomized traffic with occasional kills and resets.
      for (int i = 0; i < 600; i++) begin
         if (!bus.if_req || last_if_gnt) begin
            bus.if_req  = ($urandom_range(0, 2) != 0);
            bus.if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!bus.dm_req || last_dm_gnt) begin
            bus.dm_req   = ($urandom_range(0, 2) != 0);
            bus.dm_we    = $urandom_range(0, 1) == 1;
            bus.dm_be    = BW'($urandom);
            bus.dm_addr  = $urandom;
            bus.dm_wdata = $urandom;
         end
         bus.if_kill   = ($urandom_range(0, 7) == 0);
         bus.mem_rdata = $urandom;
         rst           = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
